// File: rtl/ro_race_arbiter.sv
// ro_race_arbiter: per-channel edge counters race to saturation.
// The first enabled counter to reach MAX wins. The winner index, tie flag,
// runner-up count and margin are latched and flagged by a one-cycle done pulse.
// If no enabled counter saturates within TIMEOUT_CYCLES RUN cycles, the race
// is abandoned and reported as a timeout.
module ro_race_arbiter #(
  parameter int WIDTH          = 8,
  parameter int CHANNELS       = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int IDXW           = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CHANNELS-1:0] ch_mask,
  input  logic [CHANNELS-1:0] osc_edge,
  output logic                busy,
  output logic                done,
  output logic [IDXW-1:0]     winner,
  output logic                tie,
  output logic                timeout,
  output logic [WIDTH-1:0]    runner_up,
  output logic [WIDTH-1:0]    margin
);

  localparam int               TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WIDTH-1:0] MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [WIDTH-1:0]    r_cnt [CHANNELS];
  logic [TW-1:0]       r_timer;
  logic [CHANNELS-1:0] r_mask;

  logic                r_busy;
  logic                r_done;
  logic [IDXW-1:0]     r_winner;
  logic                r_tie;
  logic                r_timeout;
  logic [WIDTH-1:0]    r_runner_up;
  logic [WIDTH-1:0]    r_margin;

  logic [CHANNELS-1:0] w_sat;
  logic                w_sat_any;
  logic                w_tie;
  logic                w_timer_exp;
  logic [IDXW-1:0]     w_win;
  logic [WIDTH-1:0]    w_runner;

  assign busy      = r_busy;
  assign done      = r_done;
  assign winner    = r_winner;
  assign tie       = r_tie;
  assign timeout   = r_timeout;
  assign runner_up = r_runner_up;
  assign margin    = r_margin;

  // Detection on the registered counts: saturated channels, lowest-index
  // winner, tie flag, and the best count among the remaining enabled channels.
  always_comb begin
    w_sat    = '0;
    w_win    = '0;
    w_runner = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_sat[i] = r_mask[i] && (r_cnt[i] == MAX);
    end
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      if (w_sat[i-1]) w_win = IDXW'(i - 1);
    end
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (r_mask[i] && (IDXW'(i) != w_win) && (r_cnt[i] > w_runner)) begin
        w_runner = r_cnt[i];
      end
    end
  end

  assign w_sat_any   = |w_sat;
  assign w_tie       = ($countones(w_sat) >= 2);
  assign w_timer_exp = (r_timer >= TW'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: saturation and timeout both end the race.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_sat_any || w_timer_exp) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: counters, race timer, mask capture, and registered results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
      r_timer     <= '0;
      r_mask      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_winner    <= '0;
      r_tie       <= 1'b0;
      r_timeout   <= 1'b0;
      r_runner_up <= '0;
      r_margin    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int unsigned i = 0; i < CHANNELS; i++) r_cnt[i] <= '0;
            r_timer <= '0;
            r_mask  <= ch_mask;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          // Counts freeze on the detection edge; saturation beats timeout.
          if (w_sat_any) begin
            r_done      <= 1'b1;
            r_winner    <= w_win;
            r_tie       <= w_tie;
            r_timeout   <= 1'b0;
            r_runner_up <= w_runner;
            r_margin    <= MAX - w_runner;
          end else if (w_timer_exp) begin
            r_done      <= 1'b1;
            r_winner    <= '0;
            r_tie       <= 1'b0;
            r_timeout   <= 1'b1;
            r_runner_up <= '0;
            r_margin    <= MAX;
          end else begin
            r_timer <= r_timer + TW'(1);
            for (int unsigned i = 0; i < CHANNELS; i++) begin
              if (r_mask[i] && osc_edge[i] && (r_cnt[i] != MAX)) begin
                r_cnt[i] <= r_cnt[i] + WIDTH'(1);
              end
            end
          end
        end
        S_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ro_race_arbiter.md
# ro_race_arbiter

Parametrised race arbiter for the ring-oscillator PUF datapath. It counts per-channel oscillator edge pulses for up to `CHANNELS` oscillators and stops the race when the first enabled counter saturates. It then latches the winner index and the runner-up count, which the response/ID logic downstream consumes. A race timeout and a channel-enable mask are provided; with `CHANNELS=2` it reproduces the legacy two-counter "report the other counter when one saturates, else 0" behaviour as a registered, handshaked block.

## Interface
Parameters:
- `WIDTH`, 8: bit width of each edge counter; saturation value `MAX = 2^WIDTH-1`.
- `CHANNELS`, 4: number of oscillator channels, 2..16.
- `TIMEOUT_CYCLES`, 1024: RUN cycles allowed before the race is abandoned; must be ≥1.
- `IDXW`, `$clog2(CHANNELS)`: derived width of the winner index.

Ports:
- `clk`, in, 1: the only clock.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: race request, level-sampled, accepted only in IDLE.
- `ch_mask`, in, CHANNELS: channel enables, sampled with an accepted `start`.
- `osc_edge`, in, CHANNELS: one-`clk`-wide pulse per oscillator edge, already synchronised to `clk`.
- `busy`, out, 1: high in RUN and DONE.
- `done`, out, 1: one-cycle pulse; result outputs are valid from this cycle onward.
- `winner`, out, IDXW: index of the saturated channel.
- `tie`, out, 1: more than one enabled channel saturated in the detection cycle.
- `timeout`, out, 1: race ended without saturation.
- `runner_up`, out, WIDTH: highest count among the enabled non-winner channels.
- `margin`, out, WIDTH: `MAX - runner_up`.

## Operation
- Reset (`rst_n` low at a `clk` edge) puts the block in IDLE. All counters, the timer, the mask register and every output go to 0.
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - On `start=1`: clear all counters and the timer, register `ch_mask`, and move to RUN.
  - Otherwise remain in IDLE.
- **RUN**
  - Each enabled counter `i` increments by 1 when `osc_edge[i]=1`. Masked channels stay at 0 and never win.
  - The timer increments every RUN cycle.
  - Detection uses the registered counts. If any enabled counter equals `MAX`, move to DONE and latch the results:
    - `winner` = lowest index among the enabled counters equal to `MAX`.
    - `tie` = 1 if two or more enabled counters equal `MAX`.
    - `runner_up` = maximum over enabled channels ≠ `winner`, which is `MAX` when `tie`=1. It is 0 if no other channel is enabled.
    - `margin` = `MAX - runner_up`.
    - `timeout` = 0.
  - Otherwise, if the timer has reached `TIMEOUT_CYCLES`, move to DONE with `timeout`=1 and `winner`, `tie`, `runner_up` = 0 and `margin` = `MAX`.
  - Saturation and timeout in the same cycle: saturation wins and `timeout`=0.
  - Counters never wrap. Increments stop at `MAX`, and the counts freeze in the detection cycle.
  - An all-zero `ch_mask` is legal; the race ends by timeout.
- **DONE**
  - `done`=1 for exactly one cycle, then move to IDLE.
- `start` is ignored while `busy`=1. It is not queued.
- Result outputs hold until the next DONE overwrites them or until reset.
- Reset mid-race aborts the race: no `done` pulse, and all outputs return to 0.

## Timing
- `start` sampled high in IDLE at edge t → RUN from t; `busy`=1 in the cycle after t.
- The `osc_edge` sampled at the first RUN edge counts.
- A counter reaching `MAX` at edge k → results latched at edge k+1, with `done`=1 during the cycle after k+1. Latency is one cycle from saturation to `done`.
- Edges arriving at the detection edge k+1 are not counted and do not affect `runner_up`.
- Timeout: `done` follows the `TIMEOUT_CYCLES`-th RUN cycle by one cycle.
- `busy` falls in the cycle after the `done` cycle. The earliest next `start` is accepted in that cycle.
- All outputs are registered. There is no combinational input-to-output path.

## Test plan
- **Basic race** (`WIDTH=8`, `CHANNELS=4`, `ch_mask=4'hF`): ch0 pulses every RUN cycle; ch1 pulses every second RUN cycle starting with the second; ch2 and ch3 are idle. Required: `done` one cycle after ch0 reaches 255, `winner=0`, `runner_up=127`, `margin=128`, `tie=0`, `timeout=0`.
- **Tie**: ch1 and ch2 pulse every cycle; ch0 and ch3 are idle. Required: `winner=1`, `tie=1`, `runner_up=255`, `margin=0`.
- **Timeout** (`TIMEOUT_CYCLES=1024`): all channels pulse every 8th cycle. Required: `done` after 1024 RUN cycles, `timeout=1`, `winner=0`, `runner_up=0`, `margin=255`.
- **Mask**: `ch_mask=4'b1110`; ch0 pulses every cycle, ch3 every second cycle. Required: `winner=3`, and ch0 is excluded from `runner_up` (0 if ch1 and ch2 are idle).
- **Start while busy, then reset**:
  - Re-assert `start` during RUN. Required: ignored, with a single `done`.
  - Drop `rst_n` for one cycle at RUN cycle 100. Required: `busy=0`, no `done`, all outputs 0.
- **Legacy equivalence** (`CHANNELS=2`): ch1 reaches 255 while ch0 reads 200. Required: `winner=1`, `runner_up=200`. With no saturation before timeout, `runner_up=0`.
